// File: rtl/pong_game_controller_pkg.sv
// Shared types and screen geometry for the Pong game sequencer.
// Imported by the controller top and the paddle mover.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    PLAY,
    GAME_OVER
  } game_state_e;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

endpackage

// File: rtl/pong_game_controller_paddle_mover.sv
// One paddle: top-y register stepped per frame with border clamping.
// load_initial recentres the paddle and wins over a step.
module paddle_mover
  import pong_pkg::*;
#(
  parameter int H             = 8,
  parameter int BORDER        = 4,
  parameter int PADDLE_HEIGHT = 64,
  parameter int SPEED         = 4,
  parameter int INIT_Y        = 208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       up,
  input  logic       down,
  input  logic       load_initial,
  output logic [H:0] pos
);

  localparam int BOT = SCREEN_H - BORDER - PADDLE_HEIGHT;

  localparam logic [H:0] TOP_Y  = (H+1)'(BORDER);
  localparam logic [H:0] UP_LIM = (H+1)'(BORDER + SPEED);
  localparam logic [H:0] BOT_Y  = (H+1)'(BOT);
  localparam logic [H:0] DN_LIM = (H+1)'(BOT - SPEED);
  localparam logic [H:0] SPD    = (H+1)'(SPEED);
  localparam logic [H:0] INIT   = (H+1)'(INIT_Y);

  logic [H:0] pos_d;

  // next position: recentre, or one clamped step when exactly one button held
  always_comb begin
    pos_d = pos;
    if (load_initial) begin
      pos_d = INIT;
    end else if (step && (up ^ down)) begin
      if (up) begin
        pos_d = (pos < UP_LIM) ? TOP_Y : pos - SPD;
      end else begin
        pos_d = (pos > DN_LIM) ? BOT_Y : pos + SPD;
      end
    end
  end

  // position register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pos <= INIT;
    else      pos <= pos_d;
  end

endmodule

// File: rtl/pong_game_controller.sv
// Pong game sequencer: serve/rally/point/game-over FSM, ball and scores.
// Advances once per frame_tick; all outputs are registered.
module pong_game_controller
  import pong_pkg::*;
#(
  parameter int HEIGHT_COUNTER_SIZE = 8,
  parameter int WIDTH_COUNTER_SIZE  = 9,
  parameter int INITIAL_PADDLE_1_X  = 16,
  parameter int INITIAL_PADDLE_2_X  = 616,
  parameter int INITIAL_PADDLE_Y    = 208,
  parameter int INITIAL_BALL_X      = 316,
  parameter int INITIAL_BALL_Y      = 236,
  parameter int PADDLE_WIDTH        = 8,
  parameter int PADDLE_HEIGHT       = 64,
  parameter int BALL_SIDE_SIZE      = 8,
  parameter int BORDER_PIXEL_WIDTH  = 4,
  parameter int PADDLE_SPEED        = 4,
  parameter int BALL_SPEED          = 2,
  parameter int SERVE_DELAY_FRAMES  = 60,
  parameter int WIN_SCORE           = 9,
  localparam int H  = HEIGHT_COUNTER_SIZE,
  localparam int W  = WIDTH_COUNTER_SIZE,
  localparam int SW = $clog2(WIN_SCORE + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_tick,
  input  logic          start,
  input  logic          p1_up,
  input  logic          p1_down,
  input  logic          p2_up,
  input  logic          p2_down,
  output logic [H:0]    paddle_1_pos,
  output logic [H:0]    paddle_2_pos,
  output logic [W:0]    ball_pos_x,
  output logic [H:0]    ball_pos_y,
  output logic [SW-1:0] score_1,
  output logic [SW-1:0] score_2,
  output logic [1:0]    game_state
);

  localparam int CW = (SERVE_DELAY_FRAMES > 0)
                    ? $clog2(SERVE_DELAY_FRAMES + 1) : 1;
  localparam int BRD  = BORDER_PIXEL_WIDTH;
  localparam int BALL = BALL_SIDE_SIZE;
  localparam int P1X  = INITIAL_PADDLE_1_X;
  localparam int P2X  = INITIAL_PADDLE_2_X;

  localparam logic [CW-1:0] DELAY = CW'(SERVE_DELAY_FRAMES);
  localparam logic [SW-1:0] WIN   = SW'(WIN_SCORE);
  localparam logic [SW-1:0] ONE   = SW'(1);

  localparam logic signed [W+1:0] SPD_X  = (W+2)'(BALL_SPEED);
  localparam logic signed [W+1:0] BALL_X = (W+2)'(BALL);
  localparam logic signed [W+1:0] BRD_X  = (W+2)'(BRD);
  localparam logic signed [W+1:0] MISS_R = (W+2)'(SCREEN_W - BRD - BALL);
  localparam logic signed [W+1:0] P1_L   = (W+2)'(P1X);
  localparam logic signed [W+1:0] P1_R   = (W+2)'(P1X + PADDLE_WIDTH);
  localparam logic signed [W+1:0] P2_L   = (W+2)'(P2X);
  localparam logic signed [W+1:0] P2_R   = (W+2)'(P2X + PADDLE_WIDTH);

  localparam logic signed [H+1:0] SPD_Y  = (H+2)'(BALL_SPEED);
  localparam logic signed [H+1:0] BALL_Y = (H+2)'(BALL);
  localparam logic signed [H+1:0] PH_Y   = (H+2)'(PADDLE_HEIGHT);
  localparam logic signed [H+1:0] YMIN_S = (H+2)'(BRD);
  localparam logic signed [H+1:0] YMAX_S = (H+2)'(SCREEN_H - BRD - BALL);

  localparam logic [W:0] X_INIT = (W+1)'(INITIAL_BALL_X);
  localparam logic [H:0] Y_INIT = (H+1)'(INITIAL_BALL_Y);
  localparam logic [W:0] X_BNC1 = (W+1)'(P1X + PADDLE_WIDTH);
  localparam logic [W:0] X_BNC2 = (W+1)'(P2X - BALL);
  localparam logic [H:0] Y_MIN  = (H+1)'(BRD);
  localparam logic [H:0] Y_MAX  = (H+1)'(SCREEN_H - BRD - BALL);

  game_state_e   state, state_d;
  logic [CW-1:0] serve_cnt, serve_cnt_d;
  logic [W:0]    ball_x_d;
  logic [H:0]    ball_y_d;
  logic          dir_x, dir_x_d;
  logic          dir_y, dir_y_d;
  logic [SW-1:0] score_1_d, score_2_d;
  logic [SW-1:0] inc_1, inc_2;
  logic          move_pad, load_pad;

  logic signed [W+1:0] nx;
  logic signed [H+1:0] ny, sp1, sp2;
  logic                ov1, ov2;
  logic                hit_l, hit_r, miss_l, miss_r;

  assign game_state = state;
  assign inc_1      = score_1 + ONE;
  assign inc_2      = score_2 + ONE;

  paddle_mover #(
    .H(H), .BORDER(BRD), .PADDLE_HEIGHT(PADDLE_HEIGHT),
    .SPEED(PADDLE_SPEED), .INIT_Y(INITIAL_PADDLE_Y)
  ) u_paddle_1 (
    .clk(clk), .rst(rst), .step(move_pad),
    .up(p1_up), .down(p1_down),
    .load_initial(load_pad), .pos(paddle_1_pos)
  );

  paddle_mover #(
    .H(H), .BORDER(BRD), .PADDLE_HEIGHT(PADDLE_HEIGHT),
    .SPEED(PADDLE_SPEED), .INIT_Y(INITIAL_PADDLE_Y)
  ) u_paddle_2 (
    .clk(clk), .rst(rst), .step(move_pad),
    .up(p2_up), .down(p2_down),
    .load_initial(load_pad), .pos(paddle_2_pos)
  );

  // candidate ball step plus paddle/border collision tests (signed, no wrap)
  always_comb begin
    sp1 = $signed({1'b0, paddle_1_pos});
    sp2 = $signed({1'b0, paddle_2_pos});
    nx = dir_x ? $signed({1'b0, ball_pos_x}) + SPD_X
               : $signed({1'b0, ball_pos_x}) - SPD_X;
    ny = dir_y ? $signed({1'b0, ball_pos_y}) + SPD_Y
               : $signed({1'b0, ball_pos_y}) - SPD_Y;
    ov1 = (ny + BALL_Y > sp1) && (ny < sp1 + PH_Y);
    ov2 = (ny + BALL_Y > sp2) && (ny < sp2 + PH_Y);
    hit_l = !dir_x && (nx <= P1_R) && (nx + BALL_X > P1_L) && ov1;
    hit_r = dir_x && (nx + BALL_X >= P2_L) && (nx < P2_R) && ov2;
    miss_l = (nx <= BRD_X);
    miss_r = (nx >= MISS_R);
  end

  // match FSM: next state, serve counter, ball and score updates
  always_comb begin
    state_d     = state;
    serve_cnt_d = serve_cnt;
    ball_x_d    = ball_pos_x;
    ball_y_d    = ball_pos_y;
    dir_x_d     = dir_x;
    dir_y_d     = dir_y;
    score_1_d   = score_1;
    score_2_d   = score_2;
    move_pad    = 1'b0;
    load_pad    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d     = SERVE;
          serve_cnt_d = DELAY;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          move_pad = 1'b1;
          if (serve_cnt != '0) serve_cnt_d = serve_cnt - 1'b1;
          else                 state_d     = PLAY;
        end
      end
      PLAY: begin
        if (frame_tick) begin
          move_pad = 1'b1;
          if (hit_l || hit_r || !(miss_l || miss_r)) begin
            if (ny < YMIN_S) begin
              ball_y_d = Y_MIN;
              dir_y_d  = 1'b1;
            end else if (ny > YMAX_S) begin
              ball_y_d = Y_MAX;
              dir_y_d  = 1'b0;
            end else begin
              ball_y_d = ny[H:0];
            end
          end
          if (hit_l) begin
            ball_x_d = X_BNC1;
            dir_x_d  = 1'b1;
          end else if (hit_r) begin
            ball_x_d = X_BNC2;
            dir_x_d  = 1'b0;
          end else if (miss_l || miss_r) begin
            if (miss_l) score_2_d = inc_2;
            else        score_1_d = inc_1;
            if ((miss_l ? inc_2 : inc_1) == WIN) begin
              state_d = GAME_OVER;
            end else begin
              state_d     = SERVE;
              serve_cnt_d = DELAY;
              ball_x_d    = X_INIT;
              ball_y_d    = Y_INIT;
              dir_x_d     = miss_r;
              dir_y_d     = 1'b1;
              load_pad    = 1'b1;
            end
          end else begin
            ball_x_d = nx[W:0];
          end
        end
      end
      GAME_OVER: begin
        if (start) begin
          state_d     = SERVE;
          serve_cnt_d = DELAY;
          ball_x_d    = X_INIT;
          ball_y_d    = Y_INIT;
          dir_x_d     = 1'b1;
          dir_y_d     = 1'b1;
          score_1_d   = '0;
          score_2_d   = '0;
          load_pad    = 1'b1;
        end
      end
    endcase
  end

  // game registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      serve_cnt  <= '0;
      ball_pos_x <= X_INIT;
      ball_pos_y <= Y_INIT;
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
      score_1    <= '0;
      score_2    <= '0;
    end else begin
      state      <= state_d;
      serve_cnt  <= serve_cnt_d;
      ball_pos_x <= ball_x_d;
      ball_pos_y <= ball_y_d;
      dir_x      <= dir_x_d;
      dir_y      <= dir_y_d;
      score_1    <= score_1_d;
      score_2    <= score_2_d;
    end
  end

endmodule

// File: tb/tb_pong_game_controller.sv
// Directed bench for pong_game_controller with a 3-frame serve delay.
// Expected positions are worked out by hand along one long rally.
module tb_pong_game_controller;
  import pong_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       p1_up = 1'b0, p1_down = 1'b0;
  logic       p2_up = 1'b0, p2_down = 1'b0;
  logic [8:0] paddle_1_pos, paddle_2_pos, ball_pos_y;
  logic [9:0] ball_pos_x;
  logic [3:0] score_1, score_2;
  logic [1:0] game_state;

  int checks = 0;
  int errors = 0;

  pong_game_controller #(.SERVE_DELAY_FRAMES(3)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .p1_up(p1_up), .p1_down(p1_down),
    .p2_up(p2_up), .p2_down(p2_down),
    .paddle_1_pos(paddle_1_pos), .paddle_2_pos(paddle_2_pos),
    .ball_pos_x(ball_pos_x), .ball_pos_y(ball_pos_y),
    .score_1(score_1), .score_2(score_2),
    .game_state(game_state)
  );

  always #5 clk = ~clk;

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    tick_n(5);
    checks++;
    if (game_state !== IDLE) begin
      errors++; $display("FAIL rst_state: got %0d want %0d", game_state, IDLE);
    end
    checks++;
    if (paddle_1_pos !== 9'd208 || paddle_2_pos !== 9'd208) begin
      errors++;
      $display("FAIL rst_pad: got %0d/%0d want 208/208", paddle_1_pos, paddle_2_pos);
    end
    checks++;
    if (ball_pos_x !== 10'd316 || ball_pos_y !== 9'd236) begin
      errors++;
      $display("FAIL rst_ball: got %0d,%0d want 316,236", ball_pos_x, ball_pos_y);
    end
    checks++;
    if (score_1 !== 4'd0 || score_2 !== 4'd0) begin
      errors++;
      $display("FAIL rst_score: got %0d/%0d want 0/0", score_1, score_2);
    end
  endtask

  // start coincides with a tick: the counter must not be decremented
  task automatic test_serve();
    @(negedge clk); start = 1'b1; frame_tick = 1'b1;
    @(negedge clk); start = 1'b0; frame_tick = 1'b0;
    checks++;
    if (game_state !== SERVE) begin
      errors++; $display("FAIL serve_enter: got %0d want %0d", game_state, SERVE);
    end
    tick_n(3);
    checks++;
    if (game_state !== SERVE) begin
      errors++; $display("FAIL serve_hold: got %0d want %0d", game_state, SERVE);
    end
    tick_n(1);
    checks++;
    if (game_state !== PLAY || ball_pos_x !== 10'd316) begin
      errors++;
      $display("FAIL serve_play: got st %0d x %0d want st %0d x 316", game_state, ball_pos_x, PLAY);
    end
    tick_n(1);
    checks++;
    if (ball_pos_x !== 10'd318 || ball_pos_y !== 9'd238) begin
      errors++;
      $display("FAIL first_move: got %0d,%0d want 318,238", ball_pos_x, ball_pos_y);
    end
  endtask

  task automatic test_paddle_limits();
    p1_up = 1'b1; p2_down = 1'b1;
    tick_n(50);
    chk("p1_near_top", int'(paddle_1_pos), 8);
    chk("p2_near_bot", int'(paddle_2_pos), 408);
    tick_n(1);
    chk("p1_clamp_top", int'(paddle_1_pos), 4);
    chk("p2_clamp_bot", int'(paddle_2_pos), 412);
    tick_n(1);
    chk("p1_stay_top", int'(paddle_1_pos), 4);
    chk("p2_stay_bot", int'(paddle_2_pos), 412);
    p1_down = 1'b1; p2_down = 1'b0;
    tick_n(2);
    chk("p1_both_hold", int'(paddle_1_pos), 4);
    chk("p2_none_hold", int'(paddle_2_pos), 412);
    p1_up = 1'b0; p1_down = 1'b0;
  endtask

  task automatic test_wall_bounce();
    tick_n(61);
    chk("bot_reach_y", int'(ball_pos_y), 468);
    chk("bot_reach_x", int'(ball_pos_x), 548);
    tick_n(1);
    chk("bot_clamp_y", int'(ball_pos_y), 468);
    tick_n(1);
    chk("bot_leave_y", int'(ball_pos_y), 466);
    chk("bot_leave_x", int'(ball_pos_x), 552);
  endtask

  task automatic test_hit_right();
    tick_n(28);
    chk("hit_r_x", int'(ball_pos_x), 608);
    chk("hit_r_y", int'(ball_pos_y), 410);
    tick_n(1);
    chk("after_r_x", int'(ball_pos_x), 606);
    chk("after_r_y", int'(ball_pos_y), 408);
  endtask

  task automatic test_top_bounce();
    tick_n(202);
    chk("top_reach_y", int'(ball_pos_y), 4);
    chk("top_reach_x", int'(ball_pos_x), 202);
    tick_n(1);
    chk("top_clamp_y", int'(ball_pos_y), 4);
    tick_n(1);
    chk("top_leave_y", int'(ball_pos_y), 6);
    chk("top_leave_x", int'(ball_pos_x), 198);
  endtask

  task automatic test_hit_left();
    tick_n(8);
    p1_down = 1'b1;
    tick_n(41);
    p1_down = 1'b0;
    chk("p1_moved", int'(paddle_1_pos), 168);
    tick_n(37);
    chk("pre_l_x", int'(ball_pos_x), 26);
    chk("pre_l_y", int'(ball_pos_y), 178);
    tick_n(1);
    chk("hit_l_x", int'(ball_pos_x), 24);
    chk("hit_l_y", int'(ball_pos_y), 180);
    tick_n(1);
    chk("after_l_x", int'(ball_pos_x), 26);
    chk("after_l_s2", int'(score_2), 0);
  endtask

  task automatic test_miss_left();
    tick_n(10);
    p2_up = 1'b1;
    tick_n(58);
    p2_up = 1'b0;
    chk("p2_moved", int'(paddle_2_pos), 180);
    tick_n(223);
    chk("hit_r2_x", int'(ball_pos_x), 608);
    chk("hit_r2_y", int'(ball_pos_y), 174);
    tick_n(301);
    chk("pre_miss_x", int'(ball_pos_x), 6);
    chk("pre_miss_y", int'(ball_pos_y), 434);
    chk("pre_miss_st", int'(game_state), int'(PLAY));
    tick_n(1);
    chk("miss_s2", int'(score_2), 1);
    chk("miss_s1", int'(score_1), 0);
    chk("miss_st", int'(game_state), int'(SERVE));
    chk("miss_bx", int'(ball_pos_x), 316);
    chk("miss_by", int'(ball_pos_y), 236);
    chk("miss_p1", int'(paddle_1_pos), 208);
    chk("miss_p2", int'(paddle_2_pos), 208);
    tick_n(5);
    chk("serve_dir_x", int'(ball_pos_x), 314);
    chk("serve_dir_y", int'(ball_pos_y), 238);
  endtask

  // each unattended point from a fresh match is a right miss after 160 ticks
  task automatic test_game_over();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    pulse_start();
    for (int i = 1; i <= 8; i++) begin
      tick_n(160);
      chk("point_s1", int'(score_1), i);
      chk("point_st", int'(game_state), int'(SERVE));
    end
    tick_n(159);
    chk("last_rally_st", int'(game_state), int'(PLAY));
    tick_n(1);
    chk("win_s1", int'(score_1), 9);
    chk("win_s2", int'(score_2), 0);
    chk("win_st", int'(game_state), int'(GAME_OVER));
    chk("win_bx", int'(ball_pos_x), 626);
    chk("win_by", int'(ball_pos_y), 392);
    p1_up = 1'b1;
    tick_n(3);
    p1_up = 1'b0;
    chk("frozen_st", int'(game_state), int'(GAME_OVER));
    chk("frozen_bx", int'(ball_pos_x), 626);
    chk("frozen_p1", int'(paddle_1_pos), 208);
    chk("frozen_s1", int'(score_1), 9);
    pulse_start();
    chk("restart_st", int'(game_state), int'(SERVE));
    chk("restart_s1", int'(score_1), 0);
    chk("restart_bx", int'(ball_pos_x), 316);
    chk("restart_by", int'(ball_pos_y), 236);
  endtask

  task automatic test_reset_mid_play();
    p1_up = 1'b1;
    tick_n(14);
    chk("mid_st", int'(game_state), int'(PLAY));
    chk("mid_p1", int'(paddle_1_pos), 152);
    chk("mid_bx", int'(ball_pos_x), 336);
    chk("mid_by", int'(ball_pos_y), 256);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_st", int'(game_state), int'(IDLE));
    chk("arst_p1", int'(paddle_1_pos), 208);
    chk("arst_bx", int'(ball_pos_x), 316);
    chk("arst_by", int'(ball_pos_y), 236);
    @(negedge clk);
    rst = 1'b1;
    tick_n(3);
    p1_up = 1'b0;
    chk("post_rst_st", int'(game_state), int'(IDLE));
    chk("post_rst_p1", int'(paddle_1_pos), 208);
  endtask

  initial begin
    test_reset();
    test_serve();
    test_paddle_limits();
    test_wall_bounce();
    test_hit_right();
    test_top_bounce();
    test_hit_left();
    test_miss_left();
    test_game_over();
    test_reset_mid_play();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
